// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle shared by the fetch requester (ibus), the LSU requester (dbus)
// and the single memory port behind mem_bus_arbiter.
//   master : arbiter side, drives every O_* signal
//   slave  : environment side (requesters + memory), drives every I_* signal
// Signals: I/O_ibus_* fetch bus, I/O_dbus_* load/store bus,
//          O_mem_* / I_mem_* memory port, O_timeout sticky abort flag.
interface mem_bus_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MASK_W = 4
);
  logic              I_ibus_req;
  logic              I_ibus_we;
  logic [ADDR_W-1:0] I_ibus_addr;
  logic [DATA_W-1:0] I_ibus_data;
  logic [MASK_W-1:0] I_ibus_mask;
  logic [DATA_W-1:0] O_ibus_data;
  logic              O_ibus_ack;
  logic              O_ibus_stallreq;

  logic              I_dbus_req;
  logic              I_dbus_we;
  logic [ADDR_W-1:0] I_dbus_addr;
  logic [DATA_W-1:0] I_dbus_data;
  logic [MASK_W-1:0] I_dbus_mask;
  logic [DATA_W-1:0] O_dbus_data;
  logic              O_dbus_ack;
  logic              O_dbus_stallreq;

  logic              O_mem_req;
  logic              O_mem_we;
  logic [ADDR_W-1:0] O_mem_addr;
  logic [DATA_W-1:0] O_mem_data;
  logic [MASK_W-1:0] O_mem_mask;
  logic [DATA_W-1:0] I_mem_data;
  logic              I_mem_ack;

  logic              O_timeout;

  modport master (
    input  I_ibus_req, I_ibus_we, I_ibus_addr, I_ibus_data, I_ibus_mask,
    output O_ibus_data, O_ibus_ack, O_ibus_stallreq,
    input  I_dbus_req, I_dbus_we, I_dbus_addr, I_dbus_data, I_dbus_mask,
    output O_dbus_data, O_dbus_ack, O_dbus_stallreq,
    output O_mem_req, O_mem_we, O_mem_addr, O_mem_data, O_mem_mask,
    input  I_mem_data, I_mem_ack,
    output O_timeout
  );

  modport slave (
    output I_ibus_req, I_ibus_we, I_ibus_addr, I_ibus_data, I_ibus_mask,
    input  O_ibus_data, O_ibus_ack, O_ibus_stallreq,
    output I_dbus_req, I_dbus_we, I_dbus_addr, I_dbus_data, I_dbus_mask,
    input  O_dbus_data, O_dbus_ack, O_dbus_stallreq,
    input  O_mem_req, O_mem_we, O_mem_addr, O_mem_data, O_mem_mask,
    output I_mem_data, I_mem_ack,
    input  O_timeout
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the fetch bus (ibus) and
// the load/store bus (dbus). One requester is granted at a time; its request
// is latched at grant and held on O_mem_* until the memory acks or the
// watchdog aborts (read data 0xDEADBEEF, sticky O_timeout).
// Ports: clk, rst (async, active-high), bus (mem_bus_arbiter_if.master).
// Parameters: ADDR_W, DATA_W, MASK_W, TIMEOUT (1..255, 8-bit watchdog).
// Option: define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous
// requests; otherwise dbus has fixed priority over ibus.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MASK_W  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_bus_arbiter_if.master bus
);
  localparam int unsigned       CNT_W      = 8;
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEADBEEF);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } req_t;

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              ibus_ack_q, ibus_ack_d;
  logic              dbus_ack_q, dbus_ack_d;
  logic [DATA_W-1:0] ibus_data_q, ibus_data_d;
  logic [DATA_W-1:0] dbus_data_q, dbus_data_d;
  logic              timeout_q, timeout_d;
  logic              pick_dbus;
  logic              done;
  logic [DATA_W-1:0] rdata;
`ifdef ARB_ROUND_ROBIN_EN
  logic              last_grant_q, last_grant_d;  // 1 = dbus got the last grant
`endif

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      ibus_ack_q  <= 1'b0;
      dbus_ack_q  <= 1'b0;
      ibus_data_q <= '0;
      dbus_data_q <= '0;
      timeout_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      ibus_ack_q  <= ibus_ack_d;
      dbus_ack_q  <= dbus_ack_d;
      ibus_data_q <= ibus_data_d;
      dbus_data_q <= dbus_data_d;
      timeout_q   <= timeout_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  // Next-state: arbitration in IDLE, completion/watchdog while granted
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    ibus_ack_d  = 1'b0;
    dbus_ack_d  = 1'b0;
    ibus_data_d = ibus_data_q;
    dbus_data_d = dbus_data_q;
    timeout_d   = timeout_q;
    done        = 1'b0;
    rdata       = '0;
    pick_dbus   = bus.I_dbus_req;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
    if (bus.I_dbus_req && bus.I_ibus_req) pick_dbus = ~last_grant_q;
`endif

    case (state_q)
      IDLE: begin
        // Any I_mem_ack seen here is spurious and ignored
        if (bus.I_dbus_req || bus.I_ibus_req) begin
          cnt_d     = '0;
          mem_req_d = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d = pick_dbus;
`endif
          if (pick_dbus) begin
            state_d = GNT_D;
            req_d   = '{we: bus.I_dbus_we, addr: bus.I_dbus_addr,
                        data: bus.I_dbus_data, mask: bus.I_dbus_mask};
          end else begin
            state_d = GNT_I;
            req_d   = '{we: bus.I_ibus_we, addr: bus.I_ibus_addr,
                        data: bus.I_ibus_data, mask: bus.I_ibus_mask};
          end
        end
      end
      GNT_I, GNT_D: begin
        // A real ack beats the watchdog when both land in the same cycle
        if (bus.I_mem_ack) begin
          done  = 1'b1;
          rdata = req_q.we ? '0 : bus.I_mem_data;
        end else if (cnt_q == CNT_LAST) begin
          done      = 1'b1;
          rdata     = ABORT_DATA;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (done) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == GNT_I) begin
            ibus_ack_d  = 1'b1;
            ibus_data_d = rdata;
          end else begin
            dbus_ack_d  = 1'b1;
            dbus_data_d = rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.O_mem_req  = mem_req_q;
  assign bus.O_mem_we   = req_q.we;
  assign bus.O_mem_addr = req_q.addr;
  assign bus.O_mem_data = req_q.data;
  assign bus.O_mem_mask = req_q.mask;

  assign bus.O_ibus_ack  = ibus_ack_q;
  assign bus.O_ibus_data = ibus_data_q;
  assign bus.O_dbus_ack  = dbus_ack_q;
  assign bus.O_dbus_data = dbus_data_q;
  assign bus.O_timeout   = timeout_q;

  // Stall stays up until the requester sees its completion pulse
  assign bus.O_ibus_stallreq = bus.I_ibus_req & ~ibus_ack_q;
  assign bus.O_dbus_stallreq = bus.I_dbus_req & ~dbus_ack_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed vector table, hand sequences for
// watchdog / reset / arbitration fairness, then random traffic checked
// against a transaction-level reference model.
module tb_mem_bus_arbiter;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned MASK_W  = 4;
  localparam int unsigned TIMEOUT = 8;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        ireq;   logic [31:0] iaddr;
    logic        dreq;   logic        dwe;   logic [31:0] daddr; logic [31:0] ddata; logic [3:0] dmask;
    logic        mack;   logic [31:0] mdata;
    logic        e_mreq; logic        e_mwe; logic [31:0] e_maddr; logic [31:0] e_mdata; logic [3:0] e_mmask;
    logic        e_iack; logic [31:0] e_idata;
    logic        e_dack; logic [31:0] e_ddata;
    logic        e_ist;  logic        e_dst;
  } vec_t;

  vec_t vt [10];

  // ---------------- reference model ----------------
  int          m_owner;   // 0 none, 1 ibus, 2 dbus
  int          m_age;     // grant cycles elapsed in the current transaction
  logic        m_we;
  logic [31:0] m_addr, m_data;
  logic [3:0]  m_mask;
  logic        m_iack, m_dack, m_tmo, m_last_d;
  logic [31:0] m_idata, m_ddata;

  task automatic model_reset();
    m_owner = 0; m_age = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_mask = '0;
    m_iack = 1'b0; m_dack = 1'b0; m_tmo = 1'b0; m_last_d = 1'b0;
    m_idata = '0; m_ddata = '0;
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    logic [31:0] rd;
    bit          fin;
    bit          take_d;
    m_iack = 1'b0;
    m_dack = 1'b0;
    fin    = 1'b0;
    rd     = '0;
    if (m_owner != 0) begin
      m_age++;
      if (bus.I_mem_ack) begin
        fin = 1'b1;
        rd  = m_we ? 32'h0 : bus.I_mem_data;
      end else if (m_age == int'(TIMEOUT)) begin
        fin   = 1'b1;
        rd    = 32'hDEADBEEF;
        m_tmo = 1'b1;
      end
      if (fin) begin
        if (m_owner == 1) begin m_iack = 1'b1; m_idata = rd; end
        else              begin m_dack = 1'b1; m_ddata = rd; end
        m_owner = 0;
      end
    end else if (bus.I_ibus_req || bus.I_dbus_req) begin
      take_d   = bus.I_dbus_req && !(RR && bus.I_ibus_req && m_last_d);
      m_last_d = take_d;
      m_owner  = take_d ? 2 : 1;
      m_age    = 0;
      m_we     = take_d ? bus.I_dbus_we   : bus.I_ibus_we;
      m_addr   = take_d ? bus.I_dbus_addr : bus.I_ibus_addr;
      m_data   = take_d ? bus.I_dbus_data : bus.I_ibus_data;
      m_mask   = take_d ? bus.I_dbus_mask : bus.I_ibus_mask;
    end
  endtask

  task automatic model_compare();
    check("rnd mem_req", 64'(bus.O_mem_req), 64'(m_owner != 0));
    if (m_owner != 0) begin
      check("rnd mem_we",   64'(bus.O_mem_we),   64'(m_we));
      check("rnd mem_addr", 64'(bus.O_mem_addr), 64'(m_addr));
      check("rnd mem_data", 64'(bus.O_mem_data), 64'(m_data));
      check("rnd mem_mask", 64'(bus.O_mem_mask), 64'(m_mask));
    end
    check("rnd ibus_ack", 64'(bus.O_ibus_ack), 64'(m_iack));
    check("rnd dbus_ack", 64'(bus.O_dbus_ack), 64'(m_dack));
    if (m_iack) check("rnd ibus_data", 64'(bus.O_ibus_data), 64'(m_idata));
    if (m_dack) check("rnd dbus_data", 64'(bus.O_dbus_data), 64'(m_ddata));
    check("rnd timeout",  64'(bus.O_timeout), 64'(m_tmo));
    check("rnd ibus_stall", 64'(bus.O_ibus_stallreq), 64'(bus.I_ibus_req && !m_iack));
    check("rnd dbus_stall", 64'(bus.O_dbus_stallreq), 64'(bus.I_dbus_req && !m_dack));
  endtask

  task automatic clear_inputs();
    bus.I_ibus_req = 1'b0; bus.I_ibus_we = 1'b0; bus.I_ibus_addr = '0; bus.I_ibus_data = '0; bus.I_ibus_mask = '0;
    bus.I_dbus_req = 1'b0; bus.I_dbus_we = 1'b0; bus.I_dbus_addr = '0; bus.I_dbus_data = '0; bus.I_dbus_mask = '0;
    bus.I_mem_ack  = 1'b0; bus.I_mem_data = '0;
  endtask

  // Variables used by the main sequence
  int          seen;
  bit          got [$];
  logic [1:0]  g_act;
  logic [1:0]  g_exp;

  initial begin
    // Table: ibus read with address change mid-grant, then simultaneous
    // ibus/dbus with a dbus write winning, then a spurious ack in IDLE.
    vt[0] = '{1'b1, 32'h80000000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
              1'b1, 1'b0, 32'h80000000, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
    vt[1] = '{1'b1, 32'h80000004, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
              1'b1, 1'b0, 32'h80000000, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
    vt[2] = '{1'b1, 32'h80000004, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00000413,
              1'b0, 1'b0, 32'h80000000, 32'h0, 4'hF, 1'b1, 32'h00000413, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 32'h80000004, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
              1'b0, 1'b0, 32'h80000000, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 32'h80000100, 1'b1, 1'b1, 32'h80001000, 32'h12345678, 4'b0011, 1'b0, 32'h0,
              1'b1, 1'b1, 32'h80001000, 32'h12345678, 4'b0011, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1};
    vt[5] = '{1'b1, 32'h80000100, 1'b1, 1'b1, 32'h80001000, 32'h12345678, 4'b0011, 1'b1, 32'hAAAA5555,
              1'b0, 1'b1, 32'h80001000, 32'h12345678, 4'b0011, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0};
    vt[6] = '{1'b1, 32'h80000100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
              1'b1, 1'b0, 32'h80000100, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0};
    vt[7] = '{1'b1, 32'h80000100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h00000513,
              1'b0, 1'b0, 32'h80000100, 32'h0, 4'hF, 1'b1, 32'h00000513, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[8] = '{1'b0, 32'h80000100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
              1'b0, 1'b0, 32'h80000100, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    vt[9] = '{1'b0, 32'h80000100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h0000FFFF,
              1'b0, 1'b0, 32'h80000100, 32'h0, 4'hF, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};

    // ---- reset values ----
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    check("rst mem_req",   64'(bus.O_mem_req),   64'd0);
    check("rst mem_we",    64'(bus.O_mem_we),    64'd0);
    check("rst mem_addr",  64'(bus.O_mem_addr),  64'd0);
    check("rst mem_data",  64'(bus.O_mem_data),  64'd0);
    check("rst mem_mask",  64'(bus.O_mem_mask),  64'd0);
    check("rst ibus_ack",  64'(bus.O_ibus_ack),  64'd0);
    check("rst ibus_data", 64'(bus.O_ibus_data), 64'd0);
    check("rst dbus_ack",  64'(bus.O_dbus_ack),  64'd0);
    check("rst dbus_data", 64'(bus.O_dbus_data), 64'd0);
    check("rst timeout",   64'(bus.O_timeout),   64'd0);
    check("rst ibus_stall", 64'(bus.O_ibus_stallreq), 64'd0);
    check("rst dbus_stall", 64'(bus.O_dbus_stallreq), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ---- vector table ----
    for (int i = 0; i < 10; i++) begin
      bus.I_ibus_req  = vt[i].ireq;
      bus.I_ibus_addr = vt[i].iaddr;
      bus.I_ibus_we   = 1'b0;
      bus.I_ibus_data = 32'h0;
      bus.I_ibus_mask = 4'hF;
      bus.I_dbus_req  = vt[i].dreq;
      bus.I_dbus_we   = vt[i].dwe;
      bus.I_dbus_addr = vt[i].daddr;
      bus.I_dbus_data = vt[i].ddata;
      bus.I_dbus_mask = vt[i].dmask;
      bus.I_mem_ack   = vt[i].mack;
      bus.I_mem_data  = vt[i].mdata;
      step();
      check($sformatf("vec%0d mem_req", i), 64'(bus.O_mem_req), 64'(vt[i].e_mreq));
      if (vt[i].e_mreq) begin
        check($sformatf("vec%0d mem_we", i),   64'(bus.O_mem_we),   64'(vt[i].e_mwe));
        check($sformatf("vec%0d mem_addr", i), 64'(bus.O_mem_addr), 64'(vt[i].e_maddr));
        check($sformatf("vec%0d mem_data", i), 64'(bus.O_mem_data), 64'(vt[i].e_mdata));
        check($sformatf("vec%0d mem_mask", i), 64'(bus.O_mem_mask), 64'(vt[i].e_mmask));
      end
      check($sformatf("vec%0d ibus_ack", i), 64'(bus.O_ibus_ack), 64'(vt[i].e_iack));
      check($sformatf("vec%0d dbus_ack", i), 64'(bus.O_dbus_ack), 64'(vt[i].e_dack));
      if (vt[i].e_iack) check($sformatf("vec%0d ibus_data", i), 64'(bus.O_ibus_data), 64'(vt[i].e_idata));
      if (vt[i].e_dack) check($sformatf("vec%0d dbus_data", i), 64'(bus.O_dbus_data), 64'(vt[i].e_ddata));
      check($sformatf("vec%0d ibus_stall", i), 64'(bus.O_ibus_stallreq), 64'(vt[i].e_ist));
      check($sformatf("vec%0d dbus_stall", i), 64'(bus.O_dbus_stallreq), 64'(vt[i].e_dst));
    end
    clear_inputs();

    // ---- ack in the same cycle the watchdog would fire: ack wins ----
    bus.I_dbus_req = 1'b1; bus.I_dbus_addr = 32'h80002000; bus.I_dbus_mask = 4'hF;
    step();
    for (int k = 1; k < int'(TIMEOUT); k++) begin
      step();
      check("ackwin hold mem_req", 64'(bus.O_mem_req), 64'd1);
      check("ackwin no early ack", 64'(bus.O_dbus_ack), 64'd0);
    end
    bus.I_mem_ack = 1'b1; bus.I_mem_data = 32'h0BADF00D;
    step();
    check("ackwin dbus_ack",  64'(bus.O_dbus_ack),  64'd1);
    check("ackwin dbus_data", 64'(bus.O_dbus_data), 64'h0BADF00D);
    check("ackwin timeout",   64'(bus.O_timeout),   64'd0);
    bus.I_mem_ack = 1'b0; bus.I_dbus_req = 1'b0;
    step();

    // ---- watchdog abort at grant cycle TIMEOUT ----
    bus.I_dbus_req = 1'b1; bus.I_dbus_addr = 32'h80003000;
    step();
    seen = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.O_dbus_ack) begin
        seen = k;
        break;
      end
    end
    check("tmo abort cycle", 64'(seen), 64'(TIMEOUT));
    check("tmo dbus_data",   64'(bus.O_dbus_data), 64'hDEADBEEF);
    check("tmo timeout",     64'(bus.O_timeout),   64'd1);
    bus.I_dbus_req = 1'b0;
    step();
    step();
    check("tmo sticky",      64'(bus.O_timeout),   64'd1);
    check("tmo ack one-shot", 64'(bus.O_dbus_ack), 64'd0);

    // ---- reset one cycle into an ibus grant ----
    bus.I_ibus_req = 1'b1; bus.I_ibus_addr = 32'h80004000; bus.I_ibus_mask = 4'hF;
    step();
    step();
    check("rstmid granted", 64'(bus.O_mem_req), 64'd1);
    #2;
    rst = 1'b1;
    bus.I_ibus_req = 1'b0;
    #1;
    check("rstmid async mem_req", 64'(bus.O_mem_req), 64'd0);
    check("rstmid timeout clr",   64'(bus.O_timeout), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rstmid no ibus_ack", 64'(bus.O_ibus_ack), 64'd0);
      check("rstmid idle",        64'(bus.O_mem_req),  64'd0);
    end

    // ---- both requesters held: fixed priority or alternation ----
    bus.I_ibus_req = 1'b1; bus.I_ibus_addr = 32'h80005000;
    bus.I_dbus_req = 1'b1; bus.I_dbus_addr = 32'h80006000; bus.I_dbus_we = 1'b0;
    bus.I_mem_ack  = 1'b1; bus.I_mem_data  = 32'h11112222;
    for (int k = 0; k < 14; k++) begin
      step();
      if (bus.O_dbus_ack) got.push_back(1'b1);
      else if (bus.O_ibus_ack) got.push_back(1'b0);
    end
    check("arb completions", 64'(got.size()), 64'd7);
    for (int k = 0; k < 6; k++) begin
      g_act = (k < got.size()) ? {1'b0, got[k]} : 2'd2;
      g_exp = {1'b0, (RR ? (k % 2 == 0) : 1'b1)};
      check($sformatf("arb grant%0d is_dbus", k), 64'(g_act), 64'(g_exp));
    end

    // ---- random traffic against the reference model ----
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 600; c++) begin
      if (!bus.I_ibus_req) begin
        if ($urandom_range(99) < 40) begin
          bus.I_ibus_req  = 1'b1;
          bus.I_ibus_we   = ($urandom_range(9) == 0);
          bus.I_ibus_addr = $urandom;
          bus.I_ibus_data = $urandom;
          bus.I_ibus_mask = 4'($urandom);
        end
      end else if (m_iack) begin
        if ($urandom_range(1) == 0) bus.I_ibus_req = 1'b0;
        else bus.I_ibus_addr = $urandom;
      end else if ($urandom_range(9) == 0) begin
        bus.I_ibus_addr = $urandom;
      end
      if (!bus.I_dbus_req) begin
        if ($urandom_range(99) < 40) begin
          bus.I_dbus_req  = 1'b1;
          bus.I_dbus_we   = 1'($urandom);
          bus.I_dbus_addr = $urandom;
          bus.I_dbus_data = $urandom;
          bus.I_dbus_mask = 4'($urandom);
        end
      end else if (m_dack) begin
        if ($urandom_range(1) == 0) bus.I_dbus_req = 1'b0;
        else bus.I_dbus_data = $urandom;
      end else if ($urandom_range(9) == 0) begin
        bus.I_dbus_data = $urandom;
      end
      bus.I_mem_ack  = (m_owner != 0) ? ($urandom_range(99) < 30) : ($urandom_range(99) < 5);
      bus.I_mem_data = $urandom;
      model_step();
      step();
      model_compare();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, got no finish, required finish");
    $fatal(1);
  end
endmodule
